exception_vector_unit: RTL
==========================

# exception_vector_unit

Sequential exception front-end of the multicycle datapath, directly upstream of the PC source multiplexer. When the controller flags an invalid opcode, arithmetic overflow or divide-by-zero, this block captures the return address into EPC and fetches the handler address byte from the reserved vector locations in memory. It then drives the mux's Exception_Destiny and EPC_Out inputs and signals the controller to load PC with the mux select set to the exception path.

## Interface
- VEC_BASE, 253: memory byte address of the first vector (opcode); overflow at VEC_BASE+1, div0 at VEC_BASE+2.
- MEM_LAT, 1: cycles from address issue to valid read data; legal range 1..4.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- exc_opcode  in  1  invalid-opcode request
- exc_overflow  in  1  ALU overflow request
- exc_div0  in  1  divide-by-zero request
- pc_in  in  32  current PC (already incremented past faulting instruction)
- mem_data_in  in  32  memory read data; bits [7:0] hold the vector byte
- mem_addr  out  32  vector read address
- mem_rd  out  1  memory read strobe
- Exception_Destiny  out  32  zero-extended handler address
- EPC_Out  out  32  saved return address
- exc_cause  out  2  01 opcode, 10 overflow, 11 div0, 00 none
- exc_busy  out  1  high in every non-IDLE state
- exc_pc_write  out  1  one-cycle request to load PC from Exception_Destiny

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: any request high at a clock edge -> REQ. Same edge: EPC_Out <= pc_in - 4 (32-bit wrap, pc_in=0 gives 0xFFFFFFFC), exc_cause <= winner.
- Priority on simultaneous requests: opcode > overflow > div0.
- REQ (1 cycle): mem_rd=1, mem_addr = VEC_BASE + exc_cause - 1 -> WAIT.
- WAIT (MEM_LAT cycles, internal counter): mem_rd=0, mem_addr held. At edge ending last WAIT cycle, Exception_Destiny <= {24'b0, mem_data_in[7:0]} -> DONE.
- DONE (1 cycle): exc_pc_write=1 -> IDLE.
- mem_addr = 0 in IDLE and DONE.
- Requests while not IDLE are ignored: no nesting, EPC_Out/exc_cause not overwritten.
- EPC_Out, Exception_Destiny and exc_cause hold their values in IDLE until the next accepted exception; controller uses EPC_Out for return.

## Timing
- Reset (async, any state, including mid-fetch): state IDLE, WAIT counter 0; outputs mem_addr=0, mem_rd=0, Exception_Destiny=0, EPC_Out=0, exc_cause=00, exc_busy=0, exc_pc_write=0. Requests are sampled only at edges where reset is low.
- Request accepted at edge E0: REQ during [E0,E1).
- WAIT during [E1,E1+MEM_LAT); Exception_Destiny updates at E(1+MEM_LAT).
- exc_pc_write high during [E(1+MEM_LAT), E(2+MEM_LAT)). Default MEM_LAT=1: pulse in 3rd cycle after acceptance.
- exc_busy high from E0 to E(2+MEM_LAT).
- Exception_Destiny is valid in the same cycle as exc_pc_write, so the controller loads PC at the edge that ends DONE.
- A request present on the edge leaving DONE is not accepted; the earliest re-acceptance is the first edge with the state in IDLE.

## Test plan
- Opcode trap, MEM_LAT=1: pc_in=0x40, exc_opcode pulse, memory returns 0x000000A8 for addr 253 -> mem_rd one cycle with mem_addr=253. The following cycle is the WAIT cycle, then exc_pc_write pulses in the next cycle. Expected: Exception_Destiny=0xA8, EPC_Out=0x3C, exc_cause=01.
- Simultaneous overflow+div0 with pc_in=0x100 -> mem_addr=254, exc_cause=10, EPC_Out=0xFC; div0 lost.
- Div0 with pc_in=0, mem_data_in=0xFFFFFF7C -> mem_addr=255, EPC_Out=0xFFFFFFFC, Exception_Destiny=0x0000007C (upper bits discarded).
- Nested request: exc_opcode accepted, exc_overflow pulsed during WAIT -> ignored; exc_cause stays 01, EPC_Out unchanged, exactly one exc_pc_write pulse.
- MEM_LAT=3: exc_overflow at E0 -> Exception_Destiny updates at E4, exc_pc_write high [E4,E5), exc_busy high [E0,E5).
- Reset asserted mid-WAIT, asynchronous between edges -> all outputs 0 immediately. After release, a new exc_div0 completes a full sequence with mem_addr=255.

Source files
------------

// File: rtl/exception_vector_unit.sv
// Exception front-end: latches EPC and cause, fetches the handler vector byte,
// then pulses exc_pc_write for one cycle with Exception_Destiny valid.
module exception_vector_unit #(
  parameter int VEC_BASE = 253,
  parameter int MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] Exception_Destiny,
  output logic [31:0] EPC_Out,
  output logic [1:0]  exc_cause,
  output logic        exc_busy,
  output logic        exc_pc_write
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t      state;
  logic [2:0]  wait_cnt;
  logic [1:0]  win_cause;
  logic        any_req;
  logic [31:0] vec_addr;

  // Fixed priority: opcode beats overflow beats div0.
  always_comb begin
    win_cause = 2'b00;
    if (exc_div0)     win_cause = 2'b11;
    if (exc_overflow) win_cause = 2'b10;
    if (exc_opcode)   win_cause = 2'b01;
  end

  assign any_req  = exc_opcode | exc_overflow | exc_div0;
  assign vec_addr = 32'(VEC_BASE) + {30'd0, win_cause} - 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      wait_cnt          <= 3'd0;
      mem_addr          <= 32'd0;
      mem_rd            <= 1'b0;
      Exception_Destiny <= 32'd0;
      EPC_Out           <= 32'd0;
      exc_cause         <= 2'b00;
      exc_busy          <= 1'b0;
      exc_pc_write      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= REQ;
            EPC_Out   <= pc_in - 32'd4;
            exc_cause <= win_cause;
            mem_addr  <= vec_addr;
            mem_rd    <= 1'b1;
            exc_busy  <= 1'b1;
          end
        end
        REQ: begin
          state    <= WAIT;
          mem_rd   <= 1'b0;
          wait_cnt <= LAT_M1;
        end
        WAIT: begin
          // mem_addr stays on the bus until the vector byte has been taken.
          if (wait_cnt == 3'd0) begin
            state             <= DONE;
            Exception_Destiny <= {24'd0, mem_data_in[7:0]};
            mem_addr          <= 32'd0;
            exc_pc_write      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE: begin
          state        <= IDLE;
          exc_pc_write <= 1'b0;
          exc_busy     <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
